mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl.sv | 177 +++++++++++++++++
 tb/tb_mem_ctrl.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
`timescale 1ns/1ps
// Byte-serial RAM arbiter for fetch and load/store: N-byte read done at S+N+1, store done at S+N.
// rdy low freezes all state; MEM_IO_STALL_EN holds stores to the UART window while io_buffer_full is high.
module mem_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        clear,
    input  logic        ic_valid,
    input  logic [31:0] ic_addr,
    output logic        ic_done,
    output logic [31:0] ic_data,
    input  logic        ls_valid,
    input  logic        ls_wr,
    input  logic [1:0]  ls_size,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_done,
    output logic [31:0] ls_rdata,
    output logic [31:0] mem_a,
    output logic [7:0]  mem_dout,
    output logic        mem_wr,
    input  logic [7:0]  mem_din,
    input  logic        io_buffer_full
);

    typedef enum logic [1:0] {IDLE, IFETCH, LOAD, STORE} state_t;

    state_t      state;
    logic [2:0]  cnt;
    logic [2:0]  nbytes;
    logic [31:0] a_q;
    logic [31:0] a_prev;
    logic [31:0] rbuf;
    logic [31:0] wdata_q;
    logic [7:0]  dout_q;
    logic        wr_q;
    logic        last_ic;

    logic        reading;
    logic        io_stall;
    logic [2:0]  cnt_inc;
    logic [31:0] rnext;
    logic [7:0]  wbyte_next;

    assign reading = (state == IFETCH) || (state == LOAD);
    assign cnt_inc = cnt + 3'd1;

`ifdef MEM_IO_STALL_EN
    assign io_stall = (state == STORE) && (ls_addr[17:16] == 2'b11) && io_buffer_full;
`else
    logic unused_io;
    assign unused_io = io_buffer_full;
    assign io_stall  = 1'b0;
`endif

    // The RAM keeps running while frozen, so a frozen read re-presents the
    // previous address; the byte it returns is the one captured on resume.
    assign mem_a    = (reading && !rdy) ? a_prev : a_q;
    assign mem_wr   = wr_q && rdy && !io_stall;
    assign mem_dout = dout_q;

    always_comb begin
        rnext = rbuf;
        case (cnt)
            3'd2:    rnext[15:8]  = mem_din;
            3'd3:    rnext[23:16] = mem_din;
            3'd4:    rnext[31:24] = mem_din;
            default: rnext[7:0]   = mem_din;
        endcase
    end

    always_comb begin
        case (cnt)
            3'd0:    wbyte_next = wdata_q[15:8];
            3'd1:    wbyte_next = wdata_q[23:16];
            default: wbyte_next = wdata_q[31:24];
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= 3'd0;
            nbytes   <= 3'd0;
            a_q      <= 32'd0;
            a_prev   <= 32'd0;
            rbuf     <= 32'd0;
            wdata_q  <= 32'd0;
            dout_q   <= 8'd0;
            wr_q     <= 1'b0;
            last_ic  <= 1'b1;
            ic_done  <= 1'b0;
            ls_done  <= 1'b0;
            ic_data  <= 32'd0;
            ls_rdata <= 32'd0;
        end else if (rdy) begin
            ic_done <= 1'b0;
            ls_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (!clear && (ic_valid || ls_valid)) begin
                        cnt  <= 3'd0;
                        rbuf <= 32'd0;
                        if (ls_valid && (!ic_valid || last_ic)) begin
                            last_ic <= 1'b0;
                            a_q     <= ls_addr;
                            a_prev  <= ls_addr;
                            wdata_q <= ls_wdata;
                            case (ls_size)
                                2'b00:   nbytes <= 3'd1;
                                2'b01:   nbytes <= 3'd2;
                                default: nbytes <= 3'd4;
                            endcase
                            if (ls_wr) begin
                                state  <= STORE;
                                wr_q   <= 1'b1;
                                dout_q <= ls_wdata[7:0];
                            end else begin
                                state <= LOAD;
                            end
                        end else begin
                            last_ic <= 1'b1;
                            a_q     <= ic_addr;
                            a_prev  <= ic_addr;
                            nbytes  <= 3'd4;
                            state   <= IFETCH;
                        end
                    end
                end
                IFETCH, LOAD: begin
                    if (clear) begin
                        state  <= IDLE;
                        a_q    <= 32'd0;
                        a_prev <= 32'd0;
                    end else begin
                        cnt    <= cnt_inc;
                        a_prev <= a_q;
                        if (cnt_inc < nbytes)
                            a_q <= a_q + 32'd1;
                        if (cnt != 3'd0)
                            rbuf <= rnext;
                        if (cnt == nbytes) begin
                            state  <= IDLE;
                            a_q    <= 32'd0;
                            a_prev <= 32'd0;
                            if (state == IFETCH) begin
                                ic_done <= 1'b1;
                                ic_data <= rnext;
                            end else begin
                                ls_done  <= 1'b1;
                                ls_rdata <= rnext;
                            end
                        end
                    end
                end
                STORE: begin
                    if (!io_stall) begin
                        if (cnt_inc < nbytes) begin
                            cnt    <= cnt_inc;
                            a_q    <= a_q + 32'd1;
                            dout_q <= wbyte_next;
                        end else begin
                            state   <= IDLE;
                            wr_q    <= 1'b0;
                            a_q     <= 32'd0;
                            dout_q  <= 8'd0;
                            ls_done <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
`timescale 1ns/1ps
// Bench for mem_ctrl: byte-wide RAM model plus a done-event scoreboard.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b1;
    logic        clear = 1'b0;
    logic        ic_valid = 1'b0;
    logic [31:0] ic_addr = 32'd0;
    logic        ls_valid = 1'b0;
    logic        ls_wr = 1'b0;
    logic [1:0]  ls_size = 2'd0;
    logic [31:0] ls_addr = 32'd0;
    logic [31:0] ls_wdata = 32'd0;
    logic        io_buffer_full = 1'b0;
    logic        ic_done, ls_done, mem_wr;
    logic [31:0] ic_data, ls_rdata, mem_a;
    logic [7:0]  mem_dout, mem_din;

    logic [7:0]  ram [0:4095];
    logic        pre_we = 1'b0;
    logic [11:0] pre_a = 12'd0;
    logic [7:0]  pre_d = 8'd0;

    typedef struct {
        bit          is_ic;
        int          cyc_exp;
        logic [31:0] data;
        bit          chk;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    bit          gi, ok, seen;
    int          gw;
    logic [31:0] gd;

    mem_ctrl dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
        .ic_valid(ic_valid), .ic_addr(ic_addr), .ic_done(ic_done), .ic_data(ic_data),
        .ls_valid(ls_valid), .ls_wr(ls_wr), .ls_size(ls_size), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
        .mem_a(mem_a), .mem_dout(mem_dout), .mem_wr(mem_wr), .mem_din(mem_din),
        .io_buffer_full(io_buffer_full)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (mem_wr)      ram[mem_a[11:0]] <= mem_dout;
        else if (pre_we) ram[pre_a] <= pre_d;
        mem_din <= ram[mem_a[11:0]];
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic poke(input logic [11:0] a, input logic [7:0] d);
        pre_a = a; pre_d = d; pre_we = 1'b1;
        step();
        pre_we = 1'b0;
    endtask

    task automatic wait_any(output bit is_ic, output int at, output logic [31:0] data, output bit got);
        is_ic = 1'b0; at = 0; data = 32'd0; got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (ic_done || ls_done) begin
                is_ic = ic_done;
                at    = cyc;
                data  = ic_done ? ic_data : ls_rdata;
                if (ic_done) ic_valid = 1'b0;
                else         ls_valid = 1'b0;
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        step(); step();
        n_cmp++;
        if ({ic_done, ls_done, mem_wr} !== 3'b000) begin
            n_bad++; $display("FAIL reset_flags: got %b, want 000", {ic_done, ls_done, mem_wr});
        end
        n_cmp++;
        if (mem_a !== 32'd0 || mem_dout !== 8'd0) begin
            n_bad++; $display("FAIL reset_bus: mem_a=%h dout=%h, want 0/0", mem_a, mem_dout);
        end
        n_cmp++;
        if (ic_data !== 32'd0 || ls_rdata !== 32'd0) begin
            n_bad++; $display("FAIL reset_data: ic=%h ls=%h, want 0/0", ic_data, ls_rdata);
        end
        rst = 1'b1;
        step();
    endtask

    task automatic test_fetch();
        n_cmp++;
        if (mem_a !== 32'd0 || mem_wr !== 1'b0) begin
            n_bad++; $display("FAIL idle_bus: mem_a=%h mem_wr=%b, want 0/0", mem_a, mem_wr);
        end
        ic_addr = 32'h100; ic_valid = 1'b1;
        exp_q.push_back('{1'b1, cyc + 6, 32'h0000_0513, 1'b1});
        for (int k = 0; k < 4; k++) begin
            step();
            n_cmp++;
            if (mem_a !== 32'h100 + k) begin
                n_bad++; $display("FAIL fetch_addr%0d: got %h, want %h", k, mem_a, 32'h100 + k);
            end
        end
        while (exp_q.size() > 0) begin
            wait_any(gi, gw, gd, ok);
            e = exp_q.pop_front();
            n_cmp++;
            if (!ok || gi !== e.is_ic || gw != e.cyc_exp || (e.chk && gd !== e.data)) begin
                n_bad++; $display("FAIL fetch_done: ok=%0d ic=%0d cyc=%0d data=%h, want ic=%0d cyc=%0d data=%h",
                                  ok, gi, gw, gd, e.is_ic, e.cyc_exp, e.data);
            end
        end
    endtask

    // Both requests together; lsb_first selects which side the pointer should favour.
    task automatic test_contention(input bit lsb_first, input string name);
        ic_addr = 32'h100; ic_valid = 1'b1;
        ls_addr = 32'h200; ls_size = 2'b00; ls_wr = 1'b0; ls_valid = 1'b1;
        if (lsb_first) begin
            exp_q.push_back('{1'b0, cyc + 3, 32'h0000_00FF, 1'b1});
            exp_q.push_back('{1'b1, cyc + 9, 32'h0000_0513, 1'b1});
        end else begin
            exp_q.push_back('{1'b1, cyc + 6, 32'h0000_0513, 1'b1});
            exp_q.push_back('{1'b0, cyc + 9, 32'h0000_00FF, 1'b1});
        end
        while (exp_q.size() > 0) begin
            wait_any(gi, gw, gd, ok);
            e = exp_q.pop_front();
            n_cmp++;
            if (!ok || gi !== e.is_ic || gw != e.cyc_exp || (e.chk && gd !== e.data)) begin
                n_bad++; $display("FAIL %s: ok=%0d ic=%0d cyc=%0d data=%h, want ic=%0d cyc=%0d data=%h",
                                  name, ok, gi, gw, gd, e.is_ic, e.cyc_exp, e.data);
            end
        end
    endtask

    task automatic test_store_half();
        ls_addr = 32'h300; ls_size = 2'b01; ls_wr = 1'b1; ls_wdata = 32'h0000_BEEF; ls_valid = 1'b1;
        exp_q.push_back('{1'b0, cyc + 3, 32'd0, 1'b0});
        step();
        n_cmp++;
        if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h300, 8'hEF}) begin
            n_bad++; $display("FAIL store_b0: wr=%b a=%h d=%h, want 1/300/ef", mem_wr, mem_a, mem_dout);
        end
        step();
        n_cmp++;
        if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h301, 8'hBE}) begin
            n_bad++; $display("FAIL store_b1: wr=%b a=%h d=%h, want 1/301/be", mem_wr, mem_a, mem_dout);
        end
        while (exp_q.size() > 0) begin
            wait_any(gi, gw, gd, ok);
            e = exp_q.pop_front();
            n_cmp++;
            if (!ok || gi !== e.is_ic || gw != e.cyc_exp) begin
                n_bad++; $display("FAIL store_done: ok=%0d ic=%0d cyc=%0d, want ic=0 cyc=%0d", ok, gi, gw, e.cyc_exp);
            end
        end
        ls_wr = 1'b0;
        n_cmp++;
        if (mem_wr !== 1'b0 || ram[12'h300] !== 8'hEF || ram[12'h301] !== 8'hBE) begin
            n_bad++; $display("FAIL store_ram: wr=%b ram=%h%h, want 0/beef", mem_wr, ram[12'h301], ram[12'h300]);
        end
    endtask

    task automatic test_load_sizes();
        logic [1:0]  sz  [4] = '{2'b01, 2'b10, 2'b11, 2'b00};
        logic [31:0] ad  [4] = '{32'h300, 32'h300, 32'h300, 32'h301};
        logic [31:0] dat [4] = '{32'h0000_BEEF, 32'h1234_BEEF, 32'h1234_BEEF, 32'h0000_00BE};
        int          lat [4] = '{3, 5, 5, 2};
        for (int i = 0; i < 4; i++) begin
            ls_addr = ad[i]; ls_size = sz[i]; ls_wr = 1'b0; ls_valid = 1'b1;
            exp_q.push_back('{1'b0, cyc + 1 + lat[i], dat[i], 1'b1});
            while (exp_q.size() > 0) begin
                wait_any(gi, gw, gd, ok);
                e = exp_q.pop_front();
                n_cmp++;
                if (!ok || gi !== e.is_ic || gw != e.cyc_exp || gd !== e.data) begin
                    n_bad++; $display("FAIL load_size%0d: ok=%0d ic=%0d cyc=%0d data=%h, want cyc=%0d data=%h",
                                      i, ok, gi, gw, gd, e.cyc_exp, e.data);
                end
            end
        end
    endtask

    task automatic test_clear();
        ic_addr = 32'h100; ic_valid = 1'b1;
        step(); step();
        clear = 1'b1;
        step();
        clear = 1'b0; ic_valid = 1'b0;
        n_cmp++;
        if (mem_a !== 32'd0) begin
            n_bad++; $display("FAIL clear_abort: mem_a=%h, want 0", mem_a);
        end
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (ic_done) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_bad++; $display("FAIL clear_nodone: ic_done seen=%0d, want 0", seen);
        end
        clear = 1'b1; ic_valid = 1'b1;
        step();
        clear = 1'b0; ic_valid = 1'b0;
        n_cmp++;
        if (mem_a !== 32'd0) begin
            n_bad++; $display("FAIL clear_idle: mem_a=%h, want 0", mem_a);
        end
        step();
        ls_addr = 32'h400; ls_size = 2'b10; ls_wr = 1'b1; ls_wdata = 32'h1122_3344; ls_valid = 1'b1;
        exp_q.push_back('{1'b0, cyc + 5, 32'd0, 1'b0});
        step();
        clear = 1'b1;
        while (exp_q.size() > 0) begin
            wait_any(gi, gw, gd, ok);
            e = exp_q.pop_front();
            n_cmp++;
            if (!ok || gi !== e.is_ic || gw != e.cyc_exp) begin
                n_bad++; $display("FAIL clear_store: ok=%0d ic=%0d cyc=%0d, want ic=0 cyc=%0d", ok, gi, gw, e.cyc_exp);
            end
        end
        clear = 1'b0; ls_wr = 1'b0;
        n_cmp++;
        if ({ram[12'h403], ram[12'h402], ram[12'h401], ram[12'h400]} !== 32'h1122_3344) begin
            n_bad++; $display("FAIL clear_store_ram: got %h%h%h%h, want 11223344",
                              ram[12'h403], ram[12'h402], ram[12'h401], ram[12'h400]);
        end
    endtask

    task automatic test_rdy();
        ls_addr = 32'h300; ls_size = 2'b10; ls_wr = 1'b0; ls_valid = 1'b1;
        exp_q.push_back('{1'b0, cyc + 8, 32'h1234_BEEF, 1'b1});
        step(); step(); step();
        rdy = 1'b0;
        step(); step();
        rdy = 1'b1;
        while (exp_q.size() > 0) begin
            wait_any(gi, gw, gd, ok);
            e = exp_q.pop_front();
            n_cmp++;
            if (!ok || gi !== e.is_ic || gw != e.cyc_exp || gd !== e.data) begin
                n_bad++; $display("FAIL rdy_load: ok=%0d cyc=%0d data=%h, want cyc=%0d data=%h", ok, gw, gd, e.cyc_exp, e.data);
            end
        end
        ls_addr = 32'h500; ls_size = 2'b00; ls_wr = 1'b1; ls_wdata = 32'h5A; ls_valid = 1'b1;
        step();
        rdy = 1'b0;
        #1;
        n_cmp++;
        if (mem_wr !== 1'b0) begin
            n_bad++; $display("FAIL rdy_wr_low: mem_wr=%b, want 0", mem_wr);
        end
        step();
        rdy = 1'b1;
        exp_q.push_back('{1'b0, cyc + 1, 32'd0, 1'b0});
        #1;
        n_cmp++;
        if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h500, 8'h5A}) begin
            n_bad++; $display("FAIL rdy_reissue: wr=%b a=%h d=%h, want 1/500/5a", mem_wr, mem_a, mem_dout);
        end
        while (exp_q.size() > 0) begin
            wait_any(gi, gw, gd, ok);
            e = exp_q.pop_front();
            n_cmp++;
            if (!ok || gi !== e.is_ic || gw != e.cyc_exp) begin
                n_bad++; $display("FAIL rdy_store: ok=%0d cyc=%0d, want cyc=%0d", ok, gw, e.cyc_exp);
            end
        end
        ls_wr = 1'b0;
    endtask

    task automatic test_wrap();
        ls_addr = 32'hFFFF_FFFE; ls_size = 2'b10; ls_wr = 1'b0; ls_valid = 1'b1;
        exp_q.push_back('{1'b0, cyc + 6, 32'h4433_2211, 1'b1});
        step(); step(); step();
        n_cmp++;
        if (mem_a !== 32'd0) begin
            n_bad++; $display("FAIL wrap_addr: mem_a=%h, want 00000000", mem_a);
        end
        while (exp_q.size() > 0) begin
            wait_any(gi, gw, gd, ok);
            e = exp_q.pop_front();
            n_cmp++;
            if (!ok || gi !== e.is_ic || gw != e.cyc_exp || gd !== e.data) begin
                n_bad++; $display("FAIL wrap_load: ok=%0d cyc=%0d data=%h, want cyc=%0d data=%h", ok, gw, gd, e.cyc_exp, e.data);
            end
        end
    endtask

    task automatic test_io();
        ls_addr = 32'h0003_0000; ls_size = 2'b00; ls_wr = 1'b1; ls_wdata = 32'h41; ls_valid = 1'b1;
        io_buffer_full = 1'b1;
`ifdef MEM_IO_STALL_EN
        exp_q.push_back('{1'b0, cyc + 5, 32'd0, 1'b0});
        for (int k = 0; k < 3; k++) begin
            step();
            n_cmp++;
            if (mem_wr !== 1'b0) begin
                n_bad++; $display("FAIL io_stall%0d: mem_wr=%b, want 0", k, mem_wr);
            end
        end
        step();
        io_buffer_full = 1'b0;
        #1;
        n_cmp++;
        if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h0003_0000, 8'h41}) begin
            n_bad++; $display("FAIL io_release: wr=%b a=%h d=%h, want 1/30000/41", mem_wr, mem_a, mem_dout);
        end
`else
        exp_q.push_back('{1'b0, cyc + 2, 32'd0, 1'b0});
        step();
        n_cmp++;
        if (mem_wr !== 1'b1) begin
            n_bad++; $display("FAIL io_ignored: mem_wr=%b, want 1", mem_wr);
        end
`endif
        while (exp_q.size() > 0) begin
            wait_any(gi, gw, gd, ok);
            e = exp_q.pop_front();
            n_cmp++;
            if (!ok || gi !== e.is_ic || gw != e.cyc_exp) begin
                n_bad++; $display("FAIL io_done: ok=%0d cyc=%0d, want cyc=%0d", ok, gw, e.cyc_exp);
            end
        end
        io_buffer_full = 1'b0; ls_wr = 1'b0;
        n_cmp++;
        if (ram[12'h000] !== 8'h41) begin
            n_bad++; $display("FAIL io_ram: got %h, want 41", ram[12'h000]);
        end
    endtask

    task automatic test_reset_mid();
        ls_addr = 32'h600; ls_size = 2'b10; ls_wr = 1'b1; ls_wdata = 32'hCAFE_F00D; ls_valid = 1'b1;
        step(); step();
        n_cmp++;
        if (mem_wr !== 1'b1) begin
            n_bad++; $display("FAIL rstmid_pre: mem_wr=%b, want 1", mem_wr);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({mem_wr, ls_done, mem_a} !== 34'd0 || ic_data !== 32'd0 || ls_rdata !== 32'd0) begin
            n_bad++; $display("FAIL rstmid_async: wr=%b done=%b a=%h ic=%h ls=%h, want all 0",
                              mem_wr, ls_done, mem_a, ic_data, ls_rdata);
        end
        ls_valid = 1'b0; ls_wr = 1'b0;
        step(); step();
        rst = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (ls_done || mem_wr) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_bad++; $display("FAIL rstmid_quiet: done/wr seen=%0d, want 0", seen);
        end
    endtask

    initial begin
        test_reset();
        poke(12'h100, 8'h13); poke(12'h101, 8'h05); poke(12'h102, 8'h00); poke(12'h103, 8'h00);
        poke(12'h200, 8'hFF); poke(12'h302, 8'h34); poke(12'h303, 8'h12);
        poke(12'hFFE, 8'h11); poke(12'hFFF, 8'h22); poke(12'h000, 8'h33); poke(12'h001, 8'h44);
        test_fetch();
        test_contention(1'b1, "contend_lsb");
        test_store_half();
        test_load_sizes();
        test_contention(1'b0, "contend_ic");
        test_clear();
        test_rdy();
        test_wrap();
        test_io();
        test_reset_mid();
        test_contention(1'b1, "contend_after_rst");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
